dfx_axil_reg_responder: RTL and testbench

Parametrised AXI4-Lite register responder for the DFX reconfigurable partition, replacing the static tie-off of the PCIe-to-DFX slave port. It fully handshakes every transaction and exposes an ID register, the MCU input/output control words and a configurable scratch bank. Unmapped accesses complete with DECERR rather than hanging the PCIe bridge. It sits in the DFX top, clocked by the AXI bus clock.

---
 rtl/dfx_axil_reg_responder.sv | 184 ++++++++++++++++++
 tb/tb_dfx_axil_reg_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfx_axil_reg_responder.sv
// AXI4-Lite register responder for the DFX partition slave port: ID, MCU control/status,
// decode-error counter and a scratch bank; unmapped offsets complete with DECERR.
module dfx_axil_reg_responder #(
    parameter int          NUM_SCRATCH  = 4,
    parameter int          WINDOW_BITS  = 12,
    parameter logic [31:0] ID_VALUE     = 32'hDF00_0001,
    parameter logic [31:0] CTRL_RESET   = 32'h0,
    parameter int          ERRCNT_WIDTH = 16
) (
    input  logic        AxiBusClock,
    input  logic        xAxiBusReset,
    input  logic [31:0] xPcieToDfx_AXI_awaddr,
    input  logic [2:0]  xPcieToDfx_AXI_awprot,
    input  logic        xPcieToDfx_AXI_awvalid,
    output logic        xPcieToDfx_AXI_awready,
    input  logic [31:0] xPcieToDfx_AXI_wdata,
    input  logic [3:0]  xPcieToDfx_AXI_wstrb,
    input  logic        xPcieToDfx_AXI_wvalid,
    output logic        xPcieToDfx_AXI_wready,
    output logic [1:0]  xPcieToDfx_AXI_bresp,
    output logic        xPcieToDfx_AXI_bvalid,
    input  logic        xPcieToDfx_AXI_bready,
    input  logic [31:0] xPcieToDfx_AXI_araddr,
    input  logic [2:0]  xPcieToDfx_AXI_arprot,
    input  logic        xPcieToDfx_AXI_arvalid,
    output logic        xPcieToDfx_AXI_arready,
    output logic [31:0] xPcieToDfx_AXI_rdata,
    output logic [1:0]  xPcieToDfx_AXI_rresp,
    output logic        xPcieToDfx_AXI_rvalid,
    input  logic        xPcieToDfx_AXI_rready,
    output logic [31:0] sMcuInputControl,
    input  logic [31:0] sMcuOutputControl
);

    localparam logic [1:0]              RESP_OKAY   = 2'b00;
    localparam logic [1:0]              RESP_DECERR = 2'b11;
    localparam logic [ERRCNT_WIDTH-1:0] ERRCNT_MAX  = '1;
    localparam logic [31:0]             WORD_LIMIT  = 32'(NUM_SCRATCH) + 32'd4;

    logic                    aw_held, w_held;
    logic [31:0]             aw_addr_q, w_data_q;
    logic [3:0]              w_strb_q;
    logic                    bvalid, rvalid;
    logic [1:0]              bresp, rresp;
    logic [31:0]             rdata;
    logic [31:0]             ctrl;
    logic [31:0]             scratch [NUM_SCRATCH];
    logic [ERRCNT_WIDTH-1:0] errcnt;

    logic        aw_hs, w_hs, wr_fire, ar_hs;
    logic [31:0] wr_addr, wr_data, wr_word, rd_word;
    logic [3:0]  wr_strb;
    logic        wr_hit, rd_hit, errcnt_clear;
    logic [1:0]  err_inc;
    logic [31:0] rd_value;
    logic        unused_bits;

    function automatic logic [31:0] word_index(input logic [31:0] addr);
        logic [WINDOW_BITS-1:0] off;
        off = addr[WINDOW_BITS-1:0];
        return 32'(off >> 2);
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    function automatic logic [ERRCNT_WIDTH-1:0] sat_add(input logic [ERRCNT_WIDTH-1:0] cnt,
                                                        input logic [1:0] inc);
        logic [ERRCNT_WIDTH+1:0] sum;
        sum = {2'b00, cnt} + {{ERRCNT_WIDTH{1'b0}}, inc};
        if (sum > {2'b00, ERRCNT_MAX}) return ERRCNT_MAX;
        return sum[ERRCNT_WIDTH-1:0];
    endfunction

    assign unused_bits = ^{xPcieToDfx_AXI_awprot, xPcieToDfx_AXI_arprot,
                           xPcieToDfx_AXI_awaddr, xPcieToDfx_AXI_araddr};

    assign xPcieToDfx_AXI_awready = !aw_held && !bvalid;
    assign xPcieToDfx_AXI_wready  = !w_held && !bvalid;
    assign xPcieToDfx_AXI_arready = !rvalid;
    assign xPcieToDfx_AXI_bvalid  = bvalid;
    assign xPcieToDfx_AXI_bresp   = bresp;
    assign xPcieToDfx_AXI_rvalid  = rvalid;
    assign xPcieToDfx_AXI_rresp   = rresp;
    assign xPcieToDfx_AXI_rdata   = rdata;
    assign sMcuInputControl       = ctrl;

    assign aw_hs = xPcieToDfx_AXI_awvalid && xPcieToDfx_AXI_awready;
    assign w_hs  = xPcieToDfx_AXI_wvalid && xPcieToDfx_AXI_wready;
    assign ar_hs = xPcieToDfx_AXI_arvalid && xPcieToDfx_AXI_arready;

    // A write commits in the cycle where both halves are available, held or arriving now.
    assign wr_fire = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_addr = aw_held ? aw_addr_q : xPcieToDfx_AXI_awaddr;
    assign wr_data = w_held ? w_data_q : xPcieToDfx_AXI_wdata;
    assign wr_strb = w_held ? w_strb_q : xPcieToDfx_AXI_wstrb;
    assign wr_word = word_index(wr_addr);
    assign rd_word = word_index(xPcieToDfx_AXI_araddr);
    assign wr_hit  = wr_word < WORD_LIMIT;

    assign errcnt_clear = wr_fire && (wr_word == 32'd3) && (|wr_strb);
    assign err_inc      = {1'b0, wr_fire && !wr_hit} + {1'b0, ar_hs && !rd_hit};

    always_comb begin
        rd_value = '0;
        rd_hit   = 1'b1;
        case (rd_word)
            32'd0:   rd_value = ID_VALUE;
            32'd1:   rd_value = ctrl;
            32'd2:   rd_value = sMcuOutputControl;
            32'd3:   rd_value[ERRCNT_WIDTH-1:0] = errcnt;
            default: begin
                rd_hit = 1'b0;
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (rd_word == 32'(i) + 32'd4) begin
                        rd_value = scratch[i];
                        rd_hit   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge AxiBusClock) begin
        if (xAxiBusReset) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
            ctrl    <= CTRL_RESET;
            errcnt  <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
        end else begin
            if (wr_fire) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_hit ? RESP_OKAY : RESP_DECERR;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs) w_held <= 1'b1;
                if (bvalid && xPcieToDfx_AXI_bready) bvalid <= 1'b0;
            end

            if (wr_fire && wr_word == 32'd1) ctrl <= byte_merge(ctrl, wr_data, wr_strb);
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (wr_fire && wr_word == 32'(i) + 32'd4)
                    scratch[i] <= byte_merge(scratch[i], wr_data, wr_strb);
            end

            if (errcnt_clear) errcnt <= '0;
            else errcnt <= sat_add(errcnt, err_inc);

            // Read value comes from pre-write state, so a same-edge write is not visible.
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_value;
                rresp  <= rd_hit ? RESP_OKAY : RESP_DECERR;
            end else if (rvalid && xPcieToDfx_AXI_rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge AxiBusClock) begin
        if (aw_hs) aw_addr_q <= xPcieToDfx_AXI_awaddr;
        if (w_hs) begin
            w_data_q <= xPcieToDfx_AXI_wdata;
            w_strb_q <= xPcieToDfx_AXI_wstrb;
        end
    end

endmodule

// File: tb/tb_dfx_axil_reg_responder.sv
// Randomized bench for dfx_axil_reg_responder against a transaction-level register model.
module tb_dfx_axil_reg_responder;

    localparam int          NS = 4;
    localparam int          WB = 12;
    localparam int          EW = 4;
    localparam logic [31:0] ID = 32'hDF00_0001;
    localparam logic [31:0] CR = 32'h5A00_00C3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata, ctl_out, status;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] m_ctrl;
    logic [31:0] m_scr [NS];
    int          m_err;

    dfx_axil_reg_responder #(
        .NUM_SCRATCH(NS), .WINDOW_BITS(WB), .ID_VALUE(ID), .CTRL_RESET(CR), .ERRCNT_WIDTH(EW)
    ) dut (
        .AxiBusClock(clk), .xAxiBusReset(rst),
        .xPcieToDfx_AXI_awaddr(awaddr), .xPcieToDfx_AXI_awprot(awprot),
        .xPcieToDfx_AXI_awvalid(awvalid), .xPcieToDfx_AXI_awready(awready),
        .xPcieToDfx_AXI_wdata(wdata), .xPcieToDfx_AXI_wstrb(wstrb),
        .xPcieToDfx_AXI_wvalid(wvalid), .xPcieToDfx_AXI_wready(wready),
        .xPcieToDfx_AXI_bresp(bresp), .xPcieToDfx_AXI_bvalid(bvalid),
        .xPcieToDfx_AXI_bready(bready),
        .xPcieToDfx_AXI_araddr(araddr), .xPcieToDfx_AXI_arprot(arprot),
        .xPcieToDfx_AXI_arvalid(arvalid), .xPcieToDfx_AXI_arready(arready),
        .xPcieToDfx_AXI_rdata(rdata), .xPcieToDfx_AXI_rresp(rresp),
        .xPcieToDfx_AXI_rvalid(rvalid), .xPcieToDfx_AXI_rready(rready),
        .sMcuInputControl(ctl_out), .sMcuOutputControl(status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = CR;
        m_err  = 0;
        for (int i = 0; i < NS; i++) m_scr[i] = '0;
    endtask

    task automatic model_err();
        if (m_err < (1 << EW) - 1) m_err++;
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int w;
        w = int'(a[WB-1:2]);
        r = 2'b00;
        d = '0;
        if (w == 0) d = ID;
        else if (w == 1) d = m_ctrl;
        else if (w == 2) d = status;
        else if (w == 3) d = 32'(m_err);
        else if (w < 4 + NS) d = m_scr[w-4];
        else begin
            r = 2'b11;
            model_err();
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] r);
        int w;
        w = int'(a[WB-1:2]);
        r = 2'b00;
        if (w == 1) m_ctrl = lanes(m_ctrl, d, s);
        else if (w == 3) begin
            if (s != 4'b0) m_err = 0;
        end else if (w >= 4 && w < 4 + NS) m_scr[w-4] = lanes(m_scr[w-4], d, s);
        else if (w >= 4 + NS) begin
            r = 2'b11;
            model_err();
        end
    endtask

    task automatic send_aw(input logic [31:0] a, input int dly, output int hs, output logic rdy_after);
        hs = -1;
        repeat (dly) @(negedge clk);
        awaddr  = a;
        awvalid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (awready) begin
                hs = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        awvalid   = 1'b0;
        rdy_after = awready;
        if (hs < 0) chk("aw_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly,
                          output int hs, output logic rdy_after);
        hs = -1;
        repeat (dly) @(negedge clk);
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (wready) begin
                hs = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        wvalid    = 1'b0;
        rdy_after = wready;
        if (hs < 0) chk("w_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int daw, input int dw, input int hold);
        int ha, hw;
        logic aw_after, w_after;
        logic [1:0] er;
        fork
            send_aw(a, daw, ha, aw_after);
            send_w(d, s, dw, hw, w_after);
        join
        model_write(a, d, s, er);
        chk("aw_rdy_drop", aw_after, 1'b0);
        chk("w_rdy_drop", w_after, 1'b0);
        chk("b_valid", bvalid, 1'b1);
        chk("b_latency", cyc, 32'((ha > hw ? ha : hw) + 1));
        chk("b_resp", bresp, er);
        for (int n = 0; n < hold; n++) begin
            @(negedge clk);
            chk("b_hold_valid", bvalid, 1'b1);
            chk("b_hold_resp", bresp, er);
            chk("b_hold_awrdy", awready, 1'b0);
            chk("b_hold_wrdy", wready, 1'b0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("b_done", bvalid, 1'b0);
        chk("awrdy_back", awready, 1'b1);
        chk("wrdy_back", wready, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] a, input int dly, input int hold);
        int h;
        logic [31:0] ed;
        logic [1:0]  er;
        repeat (dly) @(negedge clk);
        model_read(a, ed, er);
        araddr  = a;
        arvalid = 1'b1;
        h = -1;
        for (int n = 0; n < 40; n++) begin
            if (arready) begin
                h = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        arvalid = 1'b0;
        if (h < 0) chk("ar_timeout", 32'd0, 32'd1);
        chk("r_valid", rvalid, 1'b1);
        chk("r_latency", cyc, 32'(h + 1));
        chk("r_data", rdata, ed);
        chk("r_resp", rresp, er);
        for (int n = 0; n < hold; n++) begin
            @(negedge clk);
            chk("r_hold_valid", rvalid, 1'b1);
            chk("r_hold_data", rdata, ed);
            chk("r_hold_arrdy", arready, 1'b0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("r_done", rvalid, 1'b0);
        chk("arrdy_back", arready, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        status = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_awready", awready, 1'b1);
        chk("rst_wready", wready, 1'b1);
        chk("rst_arready", arready, 1'b1);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ctrl", ctl_out, CR);

        status = 32'hA5A5_0F0F;
        do_read(32'h0000_0000, 0, 0);
        do_read(32'h0000_0008, 0, 0);

        do_write(32'h0000_0004, 32'h1234_5678, 4'b0101, 3, 0, 0);
        chk("ctrl_strobe", ctl_out, (CR & 32'hFF00_FF00) | 32'h0034_0078);

        fork
            do_read(32'h0000_0100, 0, 0);
            do_write(32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        join
        do_read(32'h0000_000C, 0, 0);
        do_write(32'h0000_000C, 32'h0, 4'b0010, 0, 0, 0);
        do_read(32'h0000_000C, 0, 0);

        do_write(32'h0000_0014, 32'h0BAD_F00D, 4'hF, 1, 2, 5);
        do_read(32'h0000_0014, 0, 5);

        do_write(32'h0000_1000 | 32'(16 + 4*(NS-1)), 32'hCAFE_F00D, 4'hF, 0, 0, 0);
        do_read(32'(16 + 4*(NS-1)), 0, 0);
        do_read(32'(16 + 4*NS), 0, 0);
        do_write(32'(16 + 4*NS), 32'h5555_AAAA, 4'hF, 0, 1, 0);

        fork
            do_read(32'h0000_0010, 0, 0);
            do_write(32'h0000_0010, 32'h1111_2222, 4'hF, 0, 0, 0);
        join
        do_read(32'h0000_0010, 0, 0);

        for (int k = 0; k < 80; k++) begin
            logic [31:0] a;
            if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 1023)) << 2;
            else a = 32'($urandom_range(0, 4 + NS + 3)) << 2;
            a = a | ($urandom & 32'hFFFF_F003);
            status = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 3));
            end else begin
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
                chk("ctrl_mirror", ctl_out, m_ctrl);
            end
        end

        do_write(32'h0000_000C, 32'h0, 4'hF, 0, 0, 0);
        for (int k = 0; k < (1 << EW) + 3; k++) do_read(32'h0000_0800 + 32'(4*k), 0, 0);
        do_read(32'h0000_000C, 0, 0);
        chk("errcnt_sat", rdata, 32'((1 << EW) - 1));

        awaddr = 32'h0000_0004; awvalid = 1'b1;
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b0;
        chk("pre_rst_bvalid", bvalid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_bvalid", bvalid, 1'b0);
        chk("mid_rst_ctrl", ctl_out, CR);
        chk("mid_rst_awready", awready, 1'b1);
        chk("mid_rst_wready", wready, 1'b1);
        model_reset();
        do_read(32'h0000_000C, 0, 0);
        chk("mid_rst_errcnt", rdata, 32'h0);
        do_read(32'h0000_0010, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
